// File: rtl/rr_response_router.sv
// Return-path router: records each issued one-hot grant in an in-order tag FIFO and
// steers the downstream response stream to the owner of the oldest tag.
// Optional protocol error checking is enabled with `define RR_RSP_ROUTER_ERRCHK_EN.
module rr_response_router #(
  parameter int unsigned nReq      = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_issue_valid,
  input  logic [nReq-1:0]        i_issue_grant,
  output logic                   o_issue_ready,
  input  logic                   i_rsp_valid,
  input  logic [DataWidth-1:0]   i_rsp_data,
  output logic                   o_rsp_ready,
  output logic [nReq-1:0]        o_out_valid,
  output logic [DataWidth-1:0]   o_out_data,
  input  logic [nReq-1:0]        i_out_ready,
  output logic [$clog2(Depth):0] o_outstanding,
  output logic                   o_err
);

  localparam int unsigned IdxW  = (nReq > 1) ? $clog2(nReq) : 1;
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [IdxW-1:0]  r_tags [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;

  logic [AddrW-1:0] w_wr_addr;
  logic [AddrW-1:0] w_rd_addr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [IdxW-1:0]  w_grant_idx;
  logic [IdxW-1:0]  w_head_idx;
  logic [nReq-1:0]  w_head_sel;

  assign w_wr_addr = r_wr_ptr[AddrW-1:0];
  assign w_rd_addr = r_rd_ptr[AddrW-1:0];
  assign w_full    = (r_wr_ptr[PtrW-1] != r_rd_ptr[PtrW-1]) && (w_wr_addr == w_rd_addr);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);

  // Grant to index: lowest set bit wins, zero grant encodes as 0.
  always_comb begin
    w_grant_idx = '0;
    for (int i = nReq - 1; i >= 0; i--) begin
      if (i_issue_grant[i]) w_grant_idx = IdxW'(i);
    end
  end

  assign w_head_idx = r_tags[w_rd_addr];

  always_comb begin
    w_head_sel = '0;
    for (int i = 0; i < nReq; i++) begin
      w_head_sel[i] = (w_head_idx == IdxW'(i));
    end
  end

  assign o_issue_ready = !w_full;
  assign o_rsp_ready   = !w_empty && ((i_out_ready & w_head_sel) != '0);
  assign o_out_valid   = (i_rsp_valid && !w_empty) ? w_head_sel : '0;
  assign o_out_data    = i_rsp_data;
  assign o_outstanding = r_wr_ptr - r_rd_ptr;

  assign w_push = i_issue_valid && !w_full;
  assign w_pop  = i_rsp_valid && o_rsp_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
    end
  end

  // Tag storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (w_push) r_tags[w_wr_addr] <= w_grant_idx;
  end

`ifdef RR_RSP_ROUTER_ERRCHK_EN
  logic r_err;
  logic w_grant_onehot;
  logic w_err_evt;

  assign w_grant_onehot = (i_issue_grant != '0) &&
                          ((i_issue_grant & (i_issue_grant - nReq'(1))) == '0);
  assign w_err_evt = (w_push && !w_grant_onehot) ||
                     (i_rsp_valid && w_empty) ||
                     (i_issue_valid && w_full);

  always_ff @(posedge clock) begin
    if (reset)          r_err <= 1'b0;
    else if (w_err_evt) r_err <= 1'b1;
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_response_router.sv
// Directed bench for rr_response_router with a queue-based reference model
// checked every cycle plus hand-computed literal expectations.
module tb_rr_response_router;

  localparam int NREQ  = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
`ifdef RR_RSP_ROUTER_ERRCHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic            i_issue_valid;
  logic [NREQ-1:0] i_issue_grant;
  logic            o_issue_ready;
  logic            i_rsp_valid;
  logic [DW-1:0]   i_rsp_data;
  logic            o_rsp_ready;
  logic [NREQ-1:0] o_out_valid;
  logic [DW-1:0]   o_out_data;
  logic [NREQ-1:0] i_out_ready;
  logic [3:0]      o_outstanding;
  logic            o_err;

  int errors = 0;
  int checks = 0;

  rr_response_router #(.nReq(NREQ), .DataWidth(DW), .Depth(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .i_issue_valid(i_issue_valid), .i_issue_grant(i_issue_grant), .o_issue_ready(o_issue_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .o_rsp_ready(o_rsp_ready),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(i_out_ready),
    .o_outstanding(o_outstanding), .o_err(o_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int low_idx(input logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++) if (g[i]) return i;
    return 0;
  endfunction

  // Reference model: queue of owner indices, oldest first.
  int          mq[$];
  bit          m_err = 1'b0;
  bit          armed = 1'b0;
  int          m_sz;
  logic [NREQ-1:0] m_ov;
  bit          m_rr;
  bit          m_push;
  bit          m_pop;

  always @(negedge clock) begin
    if (reset) begin
      mq.delete();
      m_err = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      m_sz = mq.size();
      m_ov = '0;
      m_rr = 1'b0;
      if (m_sz > 0) begin
        m_rr = i_out_ready[mq[0]];
        if (i_rsp_valid) m_ov[mq[0]] = 1'b1;
      end
      chk("m_issue_ready", 64'(o_issue_ready), 64'(m_sz < DEPTH));
      chk("m_rsp_ready",   64'(o_rsp_ready),   64'(m_rr));
      chk("m_out_valid",   64'(o_out_valid),   64'(m_ov));
      chk("m_out_data",    64'(o_out_data),    64'(i_rsp_data));
      chk("m_outstanding", 64'(o_outstanding), 64'(m_sz));
      chk("m_err",         64'(o_err),         64'(m_err));
      m_push = i_issue_valid && (m_sz < DEPTH);
      m_pop  = i_rsp_valid && m_rr;
      if (ERR_EN)
        m_err = m_err || (m_push && ($countones(i_issue_grant) != 1)) ||
                (i_rsp_valid && m_sz == 0) || (i_issue_valid && m_sz == DEPTH);
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(low_idx(i_issue_grant));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [NREQ-1:0] g);
    i_issue_valid = 1'b1;
    i_issue_grant = g;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; i_issue_valid = 1'b0; i_issue_grant = '0;
    i_rsp_valid = 1'b0; i_rsp_data = '0; i_out_ready = 4'hF;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_issue_ready", 64'(o_issue_ready), 64'd1);
    chk("rst_rsp_ready",   64'(o_rsp_ready),   64'd0);
    chk("rst_out_valid",   64'(o_out_valid),   64'd0);
    chk("rst_outstanding", 64'(o_outstanding), 64'd0);
    chk("rst_err",         64'(o_err),         64'd0);

    // Ordered routing
    issue(4'b0100); tick(); chk("ord_occ1", 64'(o_outstanding), 64'd1);
    issue(4'b0001); tick(); chk("ord_occ2", 64'(o_outstanding), 64'd2);
    issue(4'b1000); tick(); chk("ord_occ3", 64'(o_outstanding), 64'd3);
    i_issue_valid = 1'b0;
    i_rsp_valid = 1'b1; i_rsp_data = 32'hAAAA_0001; #1;
    chk("ord_ov_a", 64'(o_out_valid), 64'b0100);
    chk("ord_od_a", 64'(o_out_data),  64'hAAAA_0001);
    tick(); i_rsp_data = 32'hBBBB_0002; #1;
    chk("ord_ov_b", 64'(o_out_valid), 64'b0001);
    tick(); i_rsp_data = 32'hCCCC_0003; #1;
    chk("ord_ov_c", 64'(o_out_valid), 64'b1000);
    tick(); i_rsp_valid = 1'b0; #1;
    chk("ord_drained", 64'(o_outstanding), 64'd0);

    // Backpressure on requester 1
    issue(4'b0010); tick(); i_issue_valid = 1'b0;
    i_out_ready = 4'b1101; i_rsp_valid = 1'b1; i_rsp_data = 32'hD00D_0004;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rsp_ready", 64'(o_rsp_ready),   64'd0);
      chk("bp_out_valid", 64'(o_out_valid),   64'b0010);
      chk("bp_out_data",  64'(o_out_data),    64'hD00D_0004);
      chk("bp_occ",       64'(o_outstanding), 64'd1);
      tick();
    end
    i_out_ready = 4'hF; #1;
    chk("bp_release", 64'(o_rsp_ready), 64'd1);
    tick(); i_rsp_valid = 1'b0; #1;
    chk("bp_drained", 64'(o_outstanding), 64'd0);

    // Full, blocked push, wrap
    for (int k = 0; k < 8; k++) begin
      issue(4'(1 << (k % 4))); tick();
    end
    issue(4'b0001); #1;
    chk("full_issue_ready", 64'(o_issue_ready), 64'd0);
    chk("full_occ",         64'(o_outstanding), 64'd8);
    tick(); #1;
    chk("full_ignored", 64'(o_outstanding), 64'd8);
    i_rsp_valid = 1'b1; i_rsp_data = 32'h300; #1;
    chk("full_pop_ready", 64'(o_rsp_ready), 64'd1);
    tick(); i_issue_valid = 1'b0; #1;
    // Push was blocked by the registered full flag, the pop still happened.
    chk("full_pop_push", 64'(o_outstanding), 64'd7);
    for (int k = 1; k < 8; k++) begin
      i_rsp_data = 32'(32'h300 + k); tick();
    end
    i_rsp_valid = 1'b0; #1;
    chk("full_drained", 64'(o_outstanding), 64'd0);
    for (int k = 0; k < 20; k++) begin
      issue(4'(1 << ((k * 3) % 4)));
      i_rsp_valid = (k > 0);
      i_rsp_data  = 32'(32'h400 + k);
      i_out_ready = (k % 4 == 2) ? 4'h0 : 4'hF;
      tick();
    end
    i_issue_valid = 1'b0; i_out_ready = 4'hF; i_rsp_valid = 1'b1;
    for (int k = 0; k < 16 && o_outstanding != 0; k++) begin
      i_rsp_data = 32'(32'h500 + k); tick();
    end
    i_rsp_valid = 1'b0; #1;
    chk("wrap_drained", 64'(o_outstanding), 64'd0);

    // Response while empty is not bypassed
    issue(4'b0001); i_rsp_valid = 1'b1; i_rsp_data = 32'hEEEE_0005; #1;
    chk("emp_rsp_ready", 64'(o_rsp_ready), 64'd0);
    chk("emp_out_valid", 64'(o_out_valid), 64'd0);
    tick(); i_issue_valid = 1'b0; #1;
    chk("emp_next_ov", 64'(o_out_valid), 64'b0001);
    chk("emp_next_rr", 64'(o_rsp_ready), 64'd1);
    tick(); i_rsp_valid = 1'b0;

    // Error flag
    do_reset(); #1;
    chk("err_after_rst", 64'(o_err), 64'd0);
    issue(4'b0110); tick(); i_issue_valid = 1'b0; #1;
    chk("err_grant", 64'(o_err), 64'(ERR_EN));
    tick(); #1;
    chk("err_sticky", 64'(o_err), 64'(ERR_EN));
    i_rsp_valid = 1'b1; #1;
    chk("err_lowbit_route", 64'(o_out_valid), 64'b0010);
    tick(); i_rsp_valid = 1'b0;
    do_reset(); #1;
    chk("err_cleared", 64'(o_err), 64'd0);
    i_rsp_valid = 1'b1; tick(); i_rsp_valid = 1'b0; #1;
    chk("err_rsp_empty", 64'(o_err), 64'(ERR_EN));

    // Reset mid-operation
    issue(4'b0001); tick();
    issue(4'b0010); tick();
    issue(4'b0100); tick();
    i_issue_valid = 1'b0;
    chk("mid_occ3", 64'(o_outstanding), 64'd3);
    do_reset();
    i_rsp_valid = 1'b1; i_rsp_data = 32'hFFFF_0006; #1;
    chk("mid_occ",         64'(o_outstanding), 64'd0);
    chk("mid_issue_ready", 64'(o_issue_ready), 64'd1);
    chk("mid_out_valid",   64'(o_out_valid),   64'd0);
    issue(4'b1000); tick(); i_issue_valid = 1'b0; #1;
    chk("mid_route", 64'(o_out_valid), 64'b1000);
    tick(); i_rsp_valid = 1'b0; #1;
    chk("mid_drained", 64'(o_outstanding), 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
